// File: rtl/sprite_ram_writer.sv
// Sprite RAM write controller: PTR/DATA/FILL/STATUS registers driving a registered RAM write port.
// RAM writes land one cycle after the bus write; PTR/DATA/FILL writes while busy are dropped and set overrun. SPRITE_WR_PACK_EN packs two pixels per DATA write.
module sprite_ram_writer #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cs,
   input  logic                  read,
   input  logic                  write,
   input  logic [1:0]            reg_addr,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr_w,
   output logic [DATA_WIDTH-1:0] din,
   output logic                  busy
);

   localparam logic [1:0] REG_PTR    = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_FILL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR1  = 2'd1;
   localparam logic [1:0] FILL = 2'd2;
`ifdef SPRITE_WR_PACK_EN
   localparam logic [1:0] WR2  = 2'd3;
`endif

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] remaining;
   logic                  overrun;
`ifdef SPRITE_WR_PACK_EN
   logic [DATA_WIDTH-1:0] hi_pix;
`endif

   logic bus_wr;
   logic wr_ptr;
   logic wr_pix;
   logic wr_fill;
   logic wr_status;
   logic abort_req;
   logic clr_overrun;
   logic collide;
   logic unused_bits;

   assign bus_wr      = cs & write;
   assign wr_ptr      = bus_wr && (reg_addr == REG_PTR);
   assign wr_pix      = bus_wr && (reg_addr == REG_DATA);
   assign wr_fill     = bus_wr && (reg_addr == REG_FILL);
   assign wr_status   = bus_wr && (reg_addr == REG_STATUS);
   assign abort_req   = wr_status & wr_data[0];
   assign clr_overrun = wr_status & wr_data[1];
   assign busy        = (state != IDLE);
   assign collide     = busy & (wr_ptr | wr_pix | wr_fill);
   // Many wr_data bits are ignored depending on register and build options.
   assign unused_bits = ^wr_data;

   always_comb begin
      rd_data = '0;
      if (cs & read) begin
         case (reg_addr)
            REG_PTR:    rd_data = {{(32-ADDR_WIDTH){1'b0}}, ptr};
            REG_STATUS: rd_data = {30'b0, overrun, busy};
            default:    rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         overrun   <= 1'b0;
         we        <= 1'b0;
         addr_w    <= '0;
         din       <= '0;
`ifdef SPRITE_WR_PACK_EN
         hi_pix    <= '0;
`endif
      end else begin
         we <= 1'b0;
         if (collide) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (wr_ptr) begin
                  ptr <= wr_data[ADDR_WIDTH-1:0];
               end else if (wr_pix) begin
                  we     <= 1'b1;
                  addr_w <= ptr;
                  din    <= wr_data[DATA_WIDTH-1:0];
                  ptr    <= ptr + ADDR_ONE;
                  state  <= WR1;
`ifdef SPRITE_WR_PACK_EN
                  hi_pix <= wr_data[16 +: DATA_WIDTH];
`endif
               end else if (wr_fill) begin
                  // A count of zero wraps to all-ones remaining, i.e. a full-RAM fill.
                  we        <= 1'b1;
                  addr_w    <= ptr;
                  din       <= wr_data[DATA_WIDTH-1:0];
                  ptr       <= ptr + ADDR_ONE;
                  remaining <= wr_data[16 +: ADDR_WIDTH] - ADDR_ONE;
                  state     <= FILL;
               end
            end
            WR1: begin
`ifdef SPRITE_WR_PACK_EN
               we     <= 1'b1;
               addr_w <= ptr;
               din    <= hi_pix;
               ptr    <= ptr + ADDR_ONE;
               state  <= WR2;
`else
               state  <= IDLE;
`endif
            end
`ifdef SPRITE_WR_PACK_EN
            WR2: begin
               state <= IDLE;
            end
`endif
            FILL: begin
               // din keeps the fill colour; ptr always points at the next unwritten word.
               if (abort_req || (remaining == '0)) begin
                  state <= IDLE;
               end else begin
                  we        <= 1'b1;
                  addr_w    <= ptr;
                  ptr       <= ptr + ADDR_ONE;
                  remaining <= remaining - ADDR_ONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Bench for sprite_ram_writer: directed cases plus random register traffic against a write-list model.
module tb_sprite_ram_writer;

   localparam int DW    = 12;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
`ifdef SPRITE_WR_PACK_EN
   localparam int DATA_DUR = 2;
`else
   localparam int DATA_DUR = 1;
`endif

   typedef logic [AW+DW-1:0] wr_t;

   logic          clk      = 1'b0;
   logic          reset_n  = 1'b0;
   logic          cs       = 1'b0;
   logic          read     = 1'b0;
   logic          write    = 1'b0;
   logic [1:0]    reg_addr = 2'd0;
   logic [31:0]   wr_data  = 32'd0;
   logic [31:0]   rd_data;
   logic          we;
   logic [AW-1:0] addr_w;
   logic [DW-1:0] din;
   logic          busy;

   wr_t mon_q[$];
   wr_t exp_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;
   int  ptr_m    = 0;
   bit  ovr_m    = 1'b0;

   sprite_ram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cs       (cs),
      .read     (read),
      .write    (write),
      .reg_addr (reg_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .we       (we),
      .addr_w   (addr_w),
      .din      (din),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n && we) mon_q.push_back({addr_w, din});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
      tick();
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic check_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] r;
      cs = 1'b1; read = 1'b1; reg_addr = a;
      #1;
      r = rd_data;
      cs = 1'b0; read = 1'b0;
      check(tag, r, exp);
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a[AW-1:0], d[DW-1:0]});
   endtask

   task automatic model_fill(input int start, input int cnt, input logic [31:0] color);
      for (int i = 0; i < cnt; i++) model_write(32'((start + i) % DEPTH), color);
   endtask

   task automatic op_data(input logic [31:0] d);
      bus_write(2'd1, d);
      model_write(32'(ptr_m), d);
      ptr_m = (ptr_m + 1) % DEPTH;
`ifdef SPRITE_WR_PACK_EN
      model_write(32'(ptr_m), {16'd0, d[31:16]});
      ptr_m = (ptr_m + 1) % DEPTH;
`endif
   endtask

   task automatic compare_writes(input string tag);
      int mism;
      mism = 0;
      check({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         if (mon_q[i] !== exp_q[i]) mism++;
      check({tag, "_content"}, 32'(mism), 32'd0);
      mon_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] color;
      int          dur, cnt, start, busy_cnt, sel;

      // Reset state
      tick(); tick();
      check("rst_we", 32'(we), 32'd0);
      check("rst_addr_w", 32'(addr_w), 32'd0);
      check("rst_din", 32'(din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_read("rst_ptr", 2'd0, 32'd0);
      check_read("rst_status", 2'd3, 32'd0);
      reset_n = 1'b1;
      tick();

      // Single DATA write at the top address, pointer wraps
      bus_write(2'd0, 32'h3FF);
      ptr_m = 'h3FF;
      op_data(32'h0000_0ABC);
      check("wr1_we", 32'(we), 32'd1);
      check("wr1_addr_w", 32'(addr_w), 32'h3FF);
      check("wr1_din", 32'(din), 32'hABC);
      check("wr1_busy", 32'(busy), 32'd1);
      repeat (DATA_DUR) tick();
      check("wr1_we_after", 32'(we), 32'd0);
      check("wr1_busy_after", 32'(busy), 32'd0);
`ifndef SPRITE_WR_PACK_EN
      check("wr1_addr_hold", 32'(addr_w), 32'h3FF);
      check("wr1_din_hold", 32'(din), 32'hABC);
`endif
      check_read("wr1_ptr_wrap", 2'd0, 32'(ptr_m));
      compare_writes("wr1");

      // Read and write in the same cycle: the read sees the old pointer
      cs = 1'b1; read = 1'b1; write = 1'b1; reg_addr = 2'd0; wr_data = 32'h155;
      #1;
      check("rw_same_cycle_old", rd_data, 32'(ptr_m));
      tick();
      cs = 1'b0; read = 1'b0; write = 1'b0;
      ptr_m = 'h155;
      check_read("rw_same_cycle_new", 2'd0, 32'h155);

      // rd_data is zero unless cs and read are both high
      cs = 1'b0; read = 1'b1; reg_addr = 2'd0;
      #1;
      check("rd_gate_no_cs", rd_data, 32'd0);
      cs = 1'b1; read = 1'b0;
      #1;
      check("rd_gate_no_read", rd_data, 32'd0);
      cs = 1'b0;

      // Five-word fill
      bus_write(2'd0, 32'h010);
      bus_write(2'd2, 32'h0005_0F00);
      model_fill('h010, 5, 32'hF00);
      ptr_m = 'h015;
      for (int i = 0; i < 5; i++) begin
         check("fill5_we", 32'(we), 32'd1);
         check("fill5_addr_w", 32'(addr_w), 32'('h010 + i));
         check("fill5_din", 32'(din), 32'hF00);
         check("fill5_busy", 32'(busy), 32'd1);
         tick();
      end
      check("fill5_we_end", 32'(we), 32'd0);
      check("fill5_busy_end", 32'(busy), 32'd0);
      check_read("fill5_ptr", 2'd0, 32'h015);
      check_read("fill5_status", 2'd3, 32'd0);
      compare_writes("fill5");

      // Count of zero fills the whole RAM with wrap-around
      bus_write(2'd0, 32'h3FE);
      color = 32'($urandom_range(0, 4095));
      bus_write(2'd2, color);
      model_fill('h3FE, DEPTH, color);
      busy_cnt = 0;
      for (int c = 0; c < 1100 && busy === 1'b1; c++) begin
         busy_cnt++;
         tick();
      end
      check("fill_all_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
      check_read("fill_all_ptr", 2'd0, 32'h3FE);
      compare_writes("fill_all");
      ptr_m = 'h3FE;

      // Collision during a fill, then abort plus overrun clear at fill cycle 10
      start = $urandom_range(0, DEPTH - 1);
      bus_write(2'd0, 32'(start));
      color = 32'($urandom_range(0, 4095));
      bus_write(2'd2, (32'd100 << 16) | color);
      tick(); tick();
      bus_write(2'd1, $urandom);
      check_read("abort_status_ovr", 2'd3, 32'h3);
      repeat (6) tick();
      bus_write(2'd3, 32'h3);
      check("abort_we", 32'(we), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      ptr_m = (start + 10) % DEPTH;
      check_read("abort_ptr", 2'd0, 32'(ptr_m));
      check_read("abort_status_clr", 2'd3, 32'd0);
      repeat (5) tick();
      check("abort_we_stays_low", 32'(we), 32'd0);
      model_fill(start, 10, color);
      compare_writes("abort");

      // Asynchronous reset in fill cycle 7
      start = $urandom_range(0, DEPTH - 1);
      bus_write(2'd0, 32'(start));
      color = 32'($urandom_range(1, 4095));
      bus_write(2'd2, (32'd50 << 16) | color);
      repeat (6) tick();
      #1 reset_n = 1'b0;
      #1;
      check("arst_we", 32'(we), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_addr_w", 32'(addr_w), 32'd0);
      check("arst_din", 32'(din), 32'd0);
      check_read("arst_ptr", 2'd0, 32'd0);
      model_fill(start, 7, color);
      compare_writes("arst_before");
      tick();
      reset_n = 1'b1;
      ptr_m = 0;
      ovr_m = 1'b0;
      repeat (60) tick();
      check("arst_busy_after", 32'(busy), 32'd0);
      check_read("arst_ptr_after", 2'd0, 32'd0);
      compare_writes("arst_after");

`ifdef SPRITE_WR_PACK_EN
      // Packed DATA write with a colliding DATA write in the first write cycle
      bus_write(2'd0, 32'h020);
      ptr_m = 'h020;
      op_data(32'h0DEF_0ABC);
      check("pack_lo_addr", 32'(addr_w), 32'h020);
      check("pack_lo_din", 32'(din), 32'hABC);
      bus_write(2'd1, 32'h0123_0456);
      ovr_m = 1'b1;
      check("pack_hi_we", 32'(we), 32'd1);
      check("pack_hi_addr", 32'(addr_w), 32'h021);
      check("pack_hi_din", 32'(din), 32'hDEF);
      tick();
      check("pack_busy_end", 32'(busy), 32'd0);
      check_read("pack_ptr", 2'd0, 32'h022);
      check_read("pack_status", 2'd3, 32'h2);
      compare_writes("pack");
`endif

      // Random register traffic
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 3);
         dur = 0;
         case (sel)
            0: begin
               d = $urandom;
               bus_write(2'd0, d);
               ptr_m = int'(d[AW-1:0]);
            end
            1: begin
               op_data($urandom);
               dur = DATA_DUR;
            end
            2: begin
               cnt = $urandom_range(1, 20);
               d = $urandom;
               d[16 +: AW] = cnt[AW-1:0];
               color = {20'd0, d[DW-1:0]};
               bus_write(2'd2, d);
               model_fill(ptr_m, cnt, color);
               ptr_m = (ptr_m + cnt) % DEPTH;
               dur = cnt;
            end
            default: begin
               bus_write(2'd3, 32'h2 | ($urandom & 32'h1));
               ovr_m = 1'b0;
            end
         endcase
         if (dur >= 2 && $urandom_range(0, 1) == 1) begin
            tick();
            bus_write(2'($urandom_range(0, 2)), $urandom);
            ovr_m = 1'b1;
            repeat (dur - 2) tick();
         end else begin
            repeat (dur) tick();
         end
         check("rnd_busy", 32'(busy), 32'd0);
         check("rnd_we", 32'(we), 32'd0);
         check_read("rnd_ptr", 2'd0, 32'(ptr_m));
         check_read("rnd_status", 2'd3, {30'd0, ovr_m, 1'b0});
         compare_writes("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
